// File: rtl/fp_block_accumulator_if.sv
// fp_block_accumulator_if: handshake/bus bundle for fp_block_accumulator.
//   Control : start (1-cycle pulse), block_len (samples per block)
//   Input   : in_data/in_ovf/in_unf with in_valid/in_ready handshake
//   Output  : out_data/out_sat with out_valid/out_ready handshake
//   master  : stimulus/upstream side; slave: the accumulator.
interface fp_block_accumulator_if #(
  parameter int W_len = 16,
  parameter int W_cnt = 8
);
  logic                    start;
  logic [W_cnt-1:0]        block_len;
  logic signed [W_len-1:0] in_data;
  logic                    in_ovf;
  logic                    in_unf;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [W_len-1:0] out_data;
  logic                    out_sat;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output start, block_len, in_data, in_ovf, in_unf, in_valid, out_ready,
    input  in_ready, out_data, out_sat, out_valid
  );

  modport slave (
    input  start, block_len, in_data, in_ovf, in_unf, in_valid, out_ready,
    output in_ready, out_data, out_sat, out_valid
  );
endinterface

// File: rtl/fp_block_accumulator.sv
// fp_block_accumulator: sums a programmable-length block of signed
// Q(W_len-W_fract).W_fract adder results in a guard-extended saturating
// accumulator and returns one W_len-bit saturated sum per block.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - fp_block_accumulator_if.slave (start/block_len, sample
//           stream with flags, result handshake)
// Optional: define FP_ACC_FLAG_CLAMP_EN to accumulate flagged samples as
//   the format bound (ovf -> +max, unf -> min, ovf wins) instead of the
//   wrapped value carried on in_data.
module fp_block_accumulator #(
  parameter int W_len   = 16,
  parameter int W_fract = 14,
  parameter int W_guard = 4,
  parameter int W_cnt   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  fp_block_accumulator_if.slave bus
);
  localparam int W_acc = W_len + W_guard;

  // Fraction position only matters to the producer/consumer; catch nonsense.
  if (W_fract >= W_len || W_len < 2 || W_guard < 1) begin : g_bad_cfg
    $error("fp_block_accumulator: bad width configuration");
  end

  localparam logic signed [W_len-1:0] S_MAX = {1'b0, {(W_len-1){1'b1}}};
  localparam logic signed [W_len-1:0] S_MIN = {1'b1, {(W_len-1){1'b0}}};
  localparam logic signed [W_acc-1:0] A_MAX = {1'b0, {(W_acc-1){1'b1}}};
  localparam logic signed [W_acc-1:0] A_MIN = {1'b1, {(W_acc-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state, state_nxt;

  logic signed [W_acc-1:0] acc;
  logic [W_cnt-1:0]        cnt, len;
  logic                    sticky;
  logic signed [W_len-1:0] out_data_q;
  logic                    out_sat_q;

  logic                    beat, last;
  logic signed [W_len-1:0] samp;
  logic signed [W_acc:0]   sum;
  logic                    acc_hit, clamp;
  logic signed [W_acc-1:0] acc_nxt;
  logic signed [W_len-1:0] out_nxt;
  logic                    sticky_nxt;

  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  assign beat = bus.in_valid & bus.in_ready;
  assign last = beat & (cnt == len - W_cnt'(1));

`ifdef FP_ACC_FLAG_CLAMP_EN
  always_comb begin
    samp = bus.in_data;
    if (bus.in_ovf)      samp = S_MAX;
    else if (bus.in_unf) samp = S_MIN;
  end
`else
  assign samp = bus.in_data;
`endif

  // One extra bit on the add: top two bits disagreeing means the W_acc
  // range was left, and the extra bit gives the direction.
  assign sum     = {acc[W_acc-1], acc} + {{(W_guard+1){samp[W_len-1]}}, samp};
  assign acc_hit = sum[W_acc] ^ sum[W_acc-1];
  assign acc_nxt = acc_hit ? (sum[W_acc] ? A_MIN : A_MAX) : sum[W_acc-1:0];

  // Fits in W_len iff all guard bits plus the W_len sign bit agree.
  assign clamp   = ~(&acc_nxt[W_acc-1:W_len-1]) & (|acc_nxt[W_acc-1:W_len-1]);
  assign out_nxt = clamp ? (acc_nxt[W_acc-1] ? S_MIN : S_MAX) : acc_nxt[W_len-1:0];
  assign sticky_nxt = sticky | acc_hit | bus.in_ovf | bus.in_unf;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && bus.block_len != '0) state_nxt = ACC;
      ACC:     if (last)                             state_nxt = DONE;
      DONE:    if (bus.out_ready)                    state_nxt = IDLE;
      default:                                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      cnt        <= '0;
      len        <= '0;
      sticky     <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      if (state == IDLE && bus.start && bus.block_len != '0) begin
        len    <= bus.block_len;
        acc    <= '0;
        cnt    <= '0;
        sticky <= 1'b0;
      end
      if (beat) begin
        acc    <= acc_nxt;
        sticky <= sticky_nxt;
        cnt    <= cnt + W_cnt'(1);
        if (last) begin
          out_data_q <= out_nxt;
          out_sat_q  <= sticky_nxt | clamp;
        end
      end
    end
  end
endmodule

// File: tb/tb_fp_block_accumulator.sv
// tb_fp_block_accumulator: directed self-checking bench for
// fp_block_accumulator with hand-computed Q2.14 block sums.
module tb_fp_block_accumulator;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  fp_block_accumulator_if #(.W_len(16), .W_cnt(8)) bus ();

  fp_block_accumulator dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  // Inputs change #1 after the rising edge; outputs are checked there too.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic start_blk(input logic [7:0] len);
    bus.start = 1'b1; bus.block_len = len;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic beat(input logic [15:0] d, input logic o = 1'b0, input logic u = 1'b0);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_ovf = o; bus.in_unf = u;
    cyc();
    bus.in_valid = 1'b0; bus.in_ovf = 1'b0; bus.in_unf = 1'b0;
  endtask

  task automatic take(input string tag, input logic [15:0] ed, input logic es);
    chk({tag, "_vld"}, 16'(bus.out_valid), 16'd1);
    chk({tag, "_data"}, bus.out_data, ed);
    chk({tag, "_sat"}, 16'(bus.out_sat), 16'(es));
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk({tag, "_vld_drop"}, 16'(bus.out_valid), 16'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.block_len = '0; bus.in_data = '0;
    bus.in_ovf = 1'b0; bus.in_unf = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_in_ready", 16'(bus.in_ready), 16'd0);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_out_data", bus.out_data, 16'h0000);
    chk("rst_out_sat", 16'(bus.out_sat), 16'd0);

    // len=3, back-to-back beats; result visible right after the last beat
    start_blk(8'd3);
    chk("t1_in_ready", 16'(bus.in_ready), 16'd1);
    bus.in_valid = 1'b1; bus.in_data = 16'h2000;
    cyc(); cyc(); cyc();
    bus.in_valid = 1'b0;
    chk("t1_vld", 16'(bus.out_valid), 16'd1);
    chk("t1_data", bus.out_data, 16'h6000);
    chk("t1_sat", 16'(bus.out_sat), 16'd0);
    // start coinciding with the DONE exit must not arm a block
    bus.out_ready = 1'b1; bus.start = 1'b1; bus.block_len = 8'd1;
    cyc();
    bus.out_ready = 1'b0; bus.start = 1'b0;
    chk("t1_exit_vld", 16'(bus.out_valid), 16'd0);
    chk("t1_exit_no_restart", 16'(bus.in_ready), 16'd0);
    cyc();
    chk("t1_exit_no_restart2", 16'(bus.in_ready), 16'd0);

    // +1.75 + -1.75 = 0
    start_blk(8'd2);
    beat(16'h7000); beat(16'h9000);
    take("t2a", 16'h0000, 1'b0);
    // 4 x 1.75 = 7.0 -> clamps at output
    start_blk(8'd4);
    for (int i = 0; i < 4; i++) beat(16'h7000);
    take("t2b", 16'h7FFF, 1'b1);

    // -3.5 -> clamps low; held under back-pressure, start in DONE ignored
    start_blk(8'd2);
    beat(16'h9000); beat(16'h9000);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin bus.start = 1'b1; bus.block_len = 8'd2; end
      chk("t3_hold_vld", 16'(bus.out_valid), 16'd1);
      chk("t3_hold_data", bus.out_data, 16'h8000);
      chk("t3_hold_sat", 16'(bus.out_sat), 16'd1);
      chk("t3_hold_in_ready", 16'(bus.in_ready), 16'd0);
      cyc();
      bus.start = 1'b0;
    end
    take("t3", 16'h8000, 1'b1);
    chk("t3_no_restart", 16'(bus.in_ready), 16'd0);

    // flagged sample: wrapped value vs clamp-to-bound
    start_blk(8'd2);
    beat(16'h8000, 1'b1, 1'b0); beat(16'h0000);
`ifdef FP_ACC_FLAG_CLAMP_EN
    take("t4_ovf", 16'h7FFF, 1'b1);
`else
    take("t4_ovf", 16'h8000, 1'b1);
`endif
    start_blk(8'd1);
    beat(16'h0010, 1'b0, 1'b1);
`ifdef FP_ACC_FLAG_CLAMP_EN
    take("t4_unf", 16'h8000, 1'b1);
`else
    take("t4_unf", 16'h0010, 1'b1);
`endif

    // 20 x 0x7FFF exceeds the 20-bit accumulator: must saturate, not wrap
    start_blk(8'd20);
    for (int i = 0; i < 20; i++) beat(16'h7FFF);
    take("t4_accsat", 16'h7FFF, 1'b1);

    // reset mid-block aborts; next block starts clean
    start_blk(8'd4);
    beat(16'h1000); beat(16'h1000);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t5_in_ready", 16'(bus.in_ready), 16'd0);
    chk("t5_out_valid", 16'(bus.out_valid), 16'd0);
    chk("t5_out_data", bus.out_data, 16'h0000);
    start_blk(8'd1);
    beat(16'h1234);
    take("t5", 16'h1234, 1'b0);

    // block_len=0 ignored; in_valid in IDLE not accumulated
    start_blk(8'd0);
    chk("t6_len0_in_ready", 16'(bus.in_ready), 16'd0);
    chk("t6_len0_out_valid", 16'(bus.out_valid), 16'd0);
    beat(16'h1000); beat(16'h1000);
    chk("t6_idle_out_valid", 16'(bus.out_valid), 16'd0);
    start_blk(8'd2);
    beat(16'h0100); beat(16'h0200);
    take("t6", 16'h0300, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
